// File: rtl/uart_reg_pkg.sv
// Shared constants and state encoding for the UART register command sequencer.
package uart_reg_pkg;

  localparam int BYTE_W = 8;

  localparam logic [BYTE_W-1:0] DEF_WR_CMD   = 8'h57;
  localparam logic [BYTE_W-1:0] DEF_RD_CMD   = 8'h52;
  localparam logic [BYTE_W-1:0] DEF_ACK_BYTE = 8'h06;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_GET_ADDR = 3'd1,
    S_GET_DATA = 3'd2,
    S_WR_REQ   = 3'd3,
    S_RD_REQ   = 3'd4,
    S_RD_CAP   = 3'd5,
    S_TX_SEND  = 3'd6
  } state_t;

endpackage

// File: rtl/uart_reg_ctrl_byte_timeout.sv
// Inter-byte gap counter: expire fires on the cycle the gap, counting that cycle, reaches TIMEOUT_CYC-1.
module byte_timeout #(
  parameter int TIMEOUT_CYC = 100000,
  parameter int TO_W        = 17
) (
  input  logic i_clk,
  input  logic i_rstb,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expire
);

  logic [TO_W-1:0] r_cnt;
  logic [TO_W-1:0] w_cnt_nxt;

  assign w_cnt_nxt = r_cnt + TO_W'(1);
  // A clear in the same cycle (accepted byte) always beats expiry.
  assign o_expire  = i_en && !i_clr && (w_cnt_nxt == TO_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge i_clk) begin
    if (!i_rstb || i_clr) r_cnt <= '0;
    else if (i_en)        r_cnt <= w_cnt_nxt;
  end

endmodule

// File: rtl/uart_reg_ctrl.sv
// Parses UART bytes into register write/read frames, strobes the register file and answers via the transmitter.
module uart_reg_ctrl
  import uart_reg_pkg::*;
#(
  parameter logic [BYTE_W-1:0] WR_CMD      = DEF_WR_CMD,
  parameter logic [BYTE_W-1:0] RD_CMD      = DEF_RD_CMD,
  parameter logic [BYTE_W-1:0] ACK_BYTE    = DEF_ACK_BYTE,
  parameter int                TIMEOUT_CYC = 100000,
  parameter int                TO_W        = 17
) (
  input  logic              i_clk,
  input  logic              i_rstb,
  input  logic              i_rx_valid,
  input  logic [BYTE_W-1:0] i_rx_data,
  input  logic              i_tx_busy,
  output logic              o_tx_start,
  output logic [BYTE_W-1:0] o_tx_data,
  output logic [BYTE_W-1:0] o_reg_addr,
  output logic [BYTE_W-1:0] o_reg_wdata,
  output logic              o_reg_we,
  output logic              o_reg_re,
  input  logic [BYTE_W-1:0] i_reg_rdata,
  output logic              o_busy,
  output logic              o_err_cmd,
  output logic              o_err_timeout,
  output logic              o_err_drop
);

  state_t            r_state, w_state_nxt;
  logic              r_op_wr, w_op_wr;
  logic [BYTE_W-1:0] r_tx_data, w_tx_data;
  logic [BYTE_W-1:0] r_reg_addr, w_reg_addr;
  logic [BYTE_W-1:0] r_reg_wdata, w_reg_wdata;
  logic              r_tx_start, w_tx_start;
  logic              r_reg_we, w_reg_we;
  logic              r_reg_re, w_reg_re;
  logic              r_err_cmd, w_err_cmd;
  logic              r_err_timeout, w_err_timeout;
  logic              r_err_drop, w_err_drop;
  logic              w_to_en, w_to_clr, w_expire;

  assign w_to_en  = (r_state == S_GET_ADDR) || (r_state == S_GET_DATA);
  assign w_to_clr = !w_to_en || i_rx_valid;

  byte_timeout #(
    .TIMEOUT_CYC (TIMEOUT_CYC),
    .TO_W        (TO_W)
  ) u_byte_timeout (
    .i_clk    (i_clk),
    .i_rstb   (i_rstb),
    .i_clr    (w_to_clr),
    .i_en     (w_to_en),
    .o_expire (w_expire)
  );

  always_ff @(posedge i_clk) begin
    if (!i_rstb) begin
      r_state       <= S_IDLE;
      r_op_wr       <= 1'b0;
      r_tx_data     <= '0;
      r_reg_addr    <= '0;
      r_reg_wdata   <= '0;
      r_tx_start    <= 1'b0;
      r_reg_we      <= 1'b0;
      r_reg_re      <= 1'b0;
      r_err_cmd     <= 1'b0;
      r_err_timeout <= 1'b0;
      r_err_drop    <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_op_wr       <= w_op_wr;
      r_tx_data     <= w_tx_data;
      r_reg_addr    <= w_reg_addr;
      r_reg_wdata   <= w_reg_wdata;
      r_tx_start    <= w_tx_start;
      r_reg_we      <= w_reg_we;
      r_reg_re      <= w_reg_re;
      r_err_cmd     <= w_err_cmd;
      r_err_timeout <= w_err_timeout;
      r_err_drop    <= w_err_drop;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:
        if (i_rx_valid && (i_rx_data == WR_CMD || i_rx_data == RD_CMD))
          w_state_nxt = S_GET_ADDR;
      S_GET_ADDR:
        if (i_rx_valid)    w_state_nxt = r_op_wr ? S_GET_DATA : S_RD_REQ;
        else if (w_expire) w_state_nxt = S_IDLE;
      S_GET_DATA:
        if (i_rx_valid)    w_state_nxt = S_WR_REQ;
        else if (w_expire) w_state_nxt = S_IDLE;
      S_WR_REQ:  w_state_nxt = S_TX_SEND;
      S_RD_REQ:  w_state_nxt = S_RD_CAP;
      // Read data lands the cycle after the visible strobe, so wait it out.
      S_RD_CAP:  if (!r_reg_re) w_state_nxt = S_TX_SEND;
      S_TX_SEND: if (!i_tx_busy) w_state_nxt = S_IDLE;
      default:   w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_op_wr       = r_op_wr;
    w_reg_addr    = r_reg_addr;
    w_reg_wdata   = r_reg_wdata;
    w_tx_data     = r_tx_data;
    w_tx_start    = 1'b0;
    w_reg_we      = 1'b0;
    w_reg_re      = 1'b0;
    w_err_cmd     = 1'b0;
    w_err_timeout = 1'b0;
    w_err_drop    = 1'b0;
    case (r_state)
      S_IDLE:
        if (i_rx_valid) begin
          if (i_rx_data == WR_CMD)      w_op_wr   = 1'b1;
          else if (i_rx_data == RD_CMD) w_op_wr   = 1'b0;
          else                          w_err_cmd = 1'b1;
        end
      S_GET_ADDR:
        if (i_rx_valid)    w_reg_addr    = i_rx_data;
        else if (w_expire) w_err_timeout = 1'b1;
      S_GET_DATA:
        if (i_rx_valid)    w_reg_wdata   = i_rx_data;
        else if (w_expire) w_err_timeout = 1'b1;
      S_WR_REQ: begin
        w_reg_we   = 1'b1;
        w_tx_data  = ACK_BYTE;
        w_err_drop = i_rx_valid;
      end
      S_RD_REQ: begin
        w_reg_re   = 1'b1;
        w_err_drop = i_rx_valid;
      end
      S_RD_CAP: begin
        if (!r_reg_re) w_tx_data = i_reg_rdata;
        w_err_drop = i_rx_valid;
      end
      S_TX_SEND: begin
        w_tx_start = !i_tx_busy;
        w_err_drop = i_rx_valid;
      end
      default: ;
    endcase
  end

  assign o_busy        = (r_state != S_IDLE);
  assign o_tx_start    = r_tx_start;
  assign o_tx_data     = r_tx_data;
  assign o_reg_addr    = r_reg_addr;
  assign o_reg_wdata   = r_reg_wdata;
  assign o_reg_we      = r_reg_we;
  assign o_reg_re      = r_reg_re;
  assign o_err_cmd     = r_err_cmd;
  assign o_err_timeout = r_err_timeout;
  assign o_err_drop    = r_err_drop;

endmodule
